pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised, handshaked pipeline stage register for the MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries NUM_DATA data words plus a control vector, with valid/ready flow control, hazard bubble insertion
//  and branch/exception flush. Generalises the fixed-width, stall-free ID/EX register to every stage boundary.
// PARAMETERS
//  DATA_W      32       width of one data word (PC+4, BusA, BusB, immediate, ...)
//  NUM_DATA    4        number of data words carried per instruction
//  CTRL_W      16       width of control vector (RegWrite, MemRead, MemWrite, ALUOp, fwd selects, ...)
//  BUBBLE_MASK 16'hFFFF ctrl bits cleared when a bubble is inserted (1 = clear, 0 = keep)
// PORTS
//  CLK        in   1                 stage clock; all state updates on negedge CLK
//  RST        in   1                 asynchronous, active-high reset
//  in_valid   in   1                 upstream instruction present
//  in_ready   out  1                 stage accepts upstream this cycle
//  in_data    in   NUM_DATA*DATA_W   upstream data words, word k at [k*DATA_W +: DATA_W]
//  in_ctrl    in   CTRL_W            upstream control vector
//  bubble     in   1                 hazard unit: insert NOP instead of accepting upstream
//  flush      in   1                 discard all held instructions
//  out_valid  out  1                 downstream instruction present
//  out_ready  in   1                 downstream consumes this cycle
//  out_data   out  NUM_DATA*DATA_W   held data words
//  out_ctrl   out  CTRL_W            held control vector
//  occ        out  2                 entries held (0..2; max 1 without skid)
// BEHAVIOUR
//  - Reset (RST=1, async): all valid bits 0, out_data/out_ctrl 0, occ 0, in_ready 0 while RST high.
//  - Accept: in_valid & in_ready at negedge; leave: out_valid & out_ready. Latency: 1 negedge in -> out.
//  - Main entry M drives out_*; out_valid = valid_M. out_data/out_ctrl hold last value when !out_valid.
//  - Priority per edge: flush > bubble > accept/drain.
//  - flush=1: all entries invalid next edge; in_ready=0; out fire that cycle still counts downstream.
//  - bubble=1 (no flush): in_ready=0 (upstream holds); if M empty or out_ready, M <= {in_data,
//    in_ctrl & ~BUBBLE_MASK}, valid_M=1 regardless of in_valid; otherwise stage holds (no NOP lost, retried).
//  - Bubble with a skid entry S valid: S moves to M first; NOP is written on a later edge.
//  - Simultaneous accept and drain with M full: M <= in, valid_M stays 1 (full throughput, no gap).
//  - Drain with no accept: valid_M <= valid_S; M <= S; valid_S <= 0.
//  - occ = valid_M + valid_S; never exceeds 2; upstream never overruns (in_ready gates acceptance).
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: 2-entry skid; in_ready = !valid_S & !flush & !bubble (registered-path,
//   no combinational out_ready->in_ready); accept with M full and !out_ready writes S.
//  PIPE_STAGE_SKID_EN undefined: single entry; in_ready = (!valid_M | out_ready) & !flush & !bubble
//   (combinational from out_ready); valid_S tied 0, occ max 1.
// STRUCTURE
//  pipe_stage_pkg: OCC_W=2, default DATA_W/CTRL_W, ctrl-field bit-position constants per stage
//   (CTRL_REGWRITE, CTRL_MEMREAD, CTRL_MEMWRITE, CTRL_ALUOP lsb/msb, CTRL_FWD_A/B), stage BUBBLE_MASKs.
//  Sub-module pipe_stage_slot: one valid+data+ctrl entry with load enable, clear, async reset;
//   instantiated as M and (under PIPE_STAGE_SKID_EN) S.
// TESTING
//  1 Reset mid-stream: RST pulse while occ=2 -> out_valid=0, occ=0, out_ctrl=0 immediately (async).
//  2 Streaming: in_valid=1, out_ready=1, ctrl 1..8 -> out_ctrl 1..8 one negedge later, no gaps.
//  3 Backpressure (skid on): out_ready=0 two cycles, feed A,B -> occ=2, in_ready=0; release -> A then B, none lost.
//  4 Bubble: in_ctrl=16'h00F5, BUBBLE_MASK=16'h00FF, bubble=1 -> out_valid=1, out_ctrl=16'h0000, in_ready=0, upstream held.
//  5 Flush with occ=2 and in_valid=1 -> next edge out_valid=0, occ=0; input not accepted.
//  6 Skid off: out_ready=0 with M full -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// Shared constants for the MIPS pipeline stage registers.
// Holds the occupancy width, default data/control widths, the bit positions of the
// control-vector fields, and the bubble masks for each stage boundary.
// Used by pipe_stage_reg and pipe_stage_slot via import pipe_stage_pkg::*.
package pipe_stage_pkg;

  localparam int unsigned OCC_W        = 2;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_DATA_DEF = 4;
  localparam int unsigned CTRL_W_DEF   = 16;

  // Control-vector field positions
  localparam int unsigned CTRL_REGWRITE  = 0;
  localparam int unsigned CTRL_MEMREAD   = 1;
  localparam int unsigned CTRL_MEMWRITE  = 2;
  localparam int unsigned CTRL_ALUOP_LSB = 3;
  localparam int unsigned CTRL_ALUOP_MSB = 6;
  localparam int unsigned CTRL_FWD_A_LSB = 7;
  localparam int unsigned CTRL_FWD_A_MSB = 8;
  localparam int unsigned CTRL_FWD_B_LSB = 9;
  localparam int unsigned CTRL_FWD_B_MSB = 10;

  // Bubble masks: 1 = bit cleared when a NOP is inserted.
  // Only state-changing fields need clearing; forwarding selects are harmless in a NOP.
  localparam logic [CTRL_W_DEF-1:0] BUBBLE_MASK_IF_ID  = 16'hFFFF;
  localparam logic [CTRL_W_DEF-1:0] BUBBLE_MASK_ID_EX  = 16'h007F;
  localparam logic [CTRL_W_DEF-1:0] BUBBLE_MASK_EX_MEM = 16'h0007;
  localparam logic [CTRL_W_DEF-1:0] BUBBLE_MASK_MEM_WB = 16'h0001;

  typedef enum logic [1:0] {
    StageIfId,
    StageIdEx,
    StageExMem,
    StageMemWb
  } stage_e;

  function automatic logic [CTRL_W_DEF-1:0] stage_bubble_mask(input stage_e st);
    logic [CTRL_W_DEF-1:0] mask;
    unique case (st)
      StageIfId:  mask = BUBBLE_MASK_IF_ID;
      StageIdEx:  mask = BUBBLE_MASK_ID_EX;
      StageExMem: mask = BUBBLE_MASK_EX_MEM;
      default:    mask = BUBBLE_MASK_MEM_WB;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline entry: valid bit plus data and control words.
// Ports:
//   clk_i   stage clock (state updates on the falling edge)
//   rst_i   asynchronous active-high reset, clears valid/data/ctrl
//   load_i  capture data_i/ctrl_i and set valid
//   clr_i   drop valid; data/ctrl keep their last value
//   data_i, ctrl_i   incoming entry
//   valid_o, data_o, ctrl_o   held entry
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_W_DEF * NUM_DATA_DEF,
  parameter int unsigned CTRL_W    = CTRL_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 clr_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic [CTRL_W-1:0]    ctrl_i,
  output logic                 valid_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic [CTRL_W-1:0]    ctrl_o
);

  logic                 valid_d, valid_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic [CTRL_W-1:0]    ctrl_d, ctrl_q;

  // Load wins over clear; the parent never asserts both.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries NUM_DATA words of DATA_W bits plus a CTRL_W control vector with valid/ready flow
// control, bubble (NOP) insertion and flush. State updates on the falling edge of CLK.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake; in_data/in_ctrl upstream payload
//   bubble                    insert a NOP (ctrl & ~BUBBLE_MASK) instead of accepting upstream
//   flush                     discard every held entry
//   out_valid/out_ready       downstream handshake; out_data/out_ctrl held payload
//   occ                       number of valid entries
// Configuration: define PIPE_STAGE_SKID_EN for a 2-entry skid buffer whose in_ready does not
// depend combinationally on out_ready; otherwise a single entry is used.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       NUM_DATA    = NUM_DATA_DEF,
  parameter int unsigned       CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] BUBBLE_MASK = {CTRL_W{1'b1}}
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic                         bubble,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [OCC_W-1:0]             occ
);

  localparam int unsigned DataBits = NUM_DATA * DATA_W;

  logic                m_valid, s_valid;
  logic [DataBits-1:0] m_data, s_data, m_data_nxt;
  logic [CTRL_W-1:0]   m_ctrl, s_ctrl, m_ctrl_nxt;
  logic                m_load, m_clr, m_from_s, m_nop;
  logic                s_load, s_clr;
  logic                accept, drain;

`ifdef PIPE_STAGE_SKID_EN
  // Depends only on state and stage-local controls, never on out_ready.
  assign in_ready = !RST && !s_valid && !flush && !bubble;
`else
  assign in_ready = !RST && (!m_valid || out_ready) && !flush && !bubble;
`endif

  assign accept = in_valid && in_ready;
  assign drain  = m_valid && out_ready;

  // Priority: flush > bubble > accept/drain.
  always_comb begin
    m_load   = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    m_nop    = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (bubble) begin
      // A held skid entry goes ahead of the NOP; if M cannot move, hold and retry.
      if (!m_valid || out_ready) begin
        m_load = 1'b1;
        if (s_valid) begin
          m_from_s = 1'b1;
          s_clr    = 1'b1;
        end else begin
          m_nop = 1'b1;
        end
      end
    end else if (drain) begin
      if (s_valid) begin
        m_load   = 1'b1;
        m_from_s = 1'b1;
        s_clr    = 1'b1;
      end else if (accept) begin
        m_load = 1'b1;
      end else begin
        m_clr = 1'b1;
      end
    end else if (accept) begin
      // Accepting with M full and no drain only happens with the skid entry present.
      if (!m_valid) begin
        m_load = 1'b1;
      end else begin
        s_load = 1'b1;
      end
    end
  end

  always_comb begin
    m_data_nxt = in_data;
    m_ctrl_nxt = in_ctrl;
    if (m_from_s) begin
      m_data_nxt = s_data;
      m_ctrl_nxt = s_ctrl;
    end else if (m_nop) begin
      m_ctrl_nxt = in_ctrl & ~BUBBLE_MASK;
    end
  end

  pipe_stage_slot #(
    .DATA_BITS(DataBits),
    .CTRL_W   (CTRL_W)
  ) u_slot_m (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (m_load),
    .clr_i  (m_clr),
    .data_i (m_data_nxt),
    .ctrl_i (m_ctrl_nxt),
    .valid_o(m_valid),
    .data_o (m_data),
    .ctrl_o (m_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_stage_slot #(
    .DATA_BITS(DataBits),
    .CTRL_W   (CTRL_W)
  ) u_slot_s (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (s_load),
    .clr_i  (s_clr),
    .data_i (in_data),
    .ctrl_i (in_ctrl),
    .valid_o(s_valid),
    .data_o (s_data),
    .ctrl_o (s_ctrl)
  );
`else
  logic unused_s_ctl;
  assign s_valid      = 1'b0;
  assign s_data       = '0;
  assign s_ctrl       = '0;
  assign unused_s_ctl = s_load | s_clr;
`endif

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;
  assign occ       = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned ND = 4;
  localparam int unsigned CW = 16;

  logic              CLK;
  logic              RST;
  logic              in_valid;
  logic              in_ready;
  logic [ND*DW-1:0]  in_data;
  logic [CW-1:0]     in_ctrl;
  logic              bubble;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ND*DW-1:0]  out_data;
  logic [CW-1:0]     out_ctrl;
  logic [1:0]        occ;

  int pass_cnt = 0;
  int total    = 0;

  pipe_stage_reg #(
    .DATA_W     (DW),
    .NUM_DATA   (ND),
    .CTRL_W     (CW),
    .BUBBLE_MASK(16'h00FF)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .bubble   (bubble),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occ      (occ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic        bub;
    logic        fl;
    logic        ordy;
    logic [15:0] tag;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_ctrl;
    logic [15:0] e_dtag;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [ND*DW-1:0] mk_data(input logic [15:0] tag);
    logic [31:0] t;
    t = {16'h0, tag};
    return {t + 32'd3, t + 32'd2, t + 32'd1, t};
  endfunction

  function automatic vec_t mk(input logic iv, input logic bub, input logic fl, input logic ordy,
                              input logic [15:0] tag, input logic e_rdy, input logic e_ov,
                              input logic [15:0] e_ctrl, input logic [15:0] e_dtag,
                              input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.bub = bub; v.fl = fl; v.ordy = ordy; v.tag = tag;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ctrl = e_ctrl; v.e_dtag = e_dtag; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [ND*DW-1:0] got,
                     input logic [ND*DW-1:0] want);
    total++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // Drive mid-cycle, check in_ready before the falling edge, outputs just after it.
  task automatic apply(input vec_t v, input int idx);
    @(posedge CLK);
    #1;
    in_valid  = v.iv;
    bubble    = v.bub;
    flush     = v.fl;
    out_ready = v.ordy;
    in_ctrl   = v.tag;
    in_data   = mk_data(v.tag);
    #1;
    chk($sformatf("in_ready[%0d]", idx), {127'h0, in_ready}, {127'h0, v.e_rdy});
    @(negedge CLK);
    #1;
    chk($sformatf("out_valid[%0d]", idx), {127'h0, out_valid}, {127'h0, v.e_ov});
    chk($sformatf("out_ctrl[%0d]", idx), {112'h0, out_ctrl}, {112'h0, v.e_ctrl});
    chk($sformatf("out_data[%0d]", idx), out_data, mk_data(v.e_dtag));
    chk($sformatf("occ[%0d]", idx), {126'h0, occ}, {126'h0, v.e_occ});
  endtask

  // Async reset in the middle of a cycle: outputs must clear before any clock edge.
  task automatic reset_pulse(input string tag);
    @(posedge CLK);
    #1;
    in_valid  = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    RST       = 1'b1;
    #1;
    chk({tag, "_ov"}, {127'h0, out_valid}, 128'h0);
    chk({tag, "_occ"}, {126'h0, occ}, 128'h0);
    chk({tag, "_ctrl"}, {112'h0, out_ctrl}, 128'h0);
    chk({tag, "_data"}, out_data, 128'h0);
    chk({tag, "_rdy"}, {127'h0, in_ready}, 128'h0);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    #1;
    chk({tag, "_ov_after"}, {127'h0, out_valid}, 128'h0);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    #12;
    chk("rst_ov", {127'h0, out_valid}, 128'h0);
    chk("rst_occ", {126'h0, occ}, 128'h0);
    chk("rst_ctrl", {112'h0, out_ctrl}, 128'h0);
    chk("rst_data", out_data, 128'h0);
    chk("rst_rdy", {127'h0, in_ready}, 128'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

`ifdef PIPE_STAGE_SKID_EN
    // Backpressure into the skid entry, then release: A then B, none lost.
    tbl.push_back(mk(1, 0, 0, 0, 16'h00A1, 1, 1, 16'h00A1, 16'h00A1, 2'd1));
    tbl.push_back(mk(1, 0, 0, 0, 16'h00B2, 1, 1, 16'h00A1, 16'h00A1, 2'd2));
    tbl.push_back(mk(1, 0, 0, 0, 16'h00C3, 0, 1, 16'h00A1, 16'h00A1, 2'd2));
    tbl.push_back(mk(0, 0, 0, 1, 16'h00C3, 0, 1, 16'h00B2, 16'h00B2, 2'd1));
    tbl.push_back(mk(0, 0, 0, 1, 16'h00C3, 1, 0, 16'h00B2, 16'h00B2, 2'd0));
    // Flush with two entries and a pending input.
    tbl.push_back(mk(1, 0, 0, 0, 16'h00A1, 1, 1, 16'h00A1, 16'h00A1, 2'd1));
    tbl.push_back(mk(1, 0, 0, 0, 16'h00B2, 1, 1, 16'h00A1, 16'h00A1, 2'd2));
    tbl.push_back(mk(1, 0, 1, 0, 16'h00D4, 0, 0, 16'h00A1, 16'h00A1, 2'd0));
    // Bubble with the skid entry full: S moves to M first, then the NOP.
    tbl.push_back(mk(1, 0, 0, 0, 16'h00A1, 1, 1, 16'h00A1, 16'h00A1, 2'd1));
    tbl.push_back(mk(1, 0, 0, 0, 16'h00B2, 1, 1, 16'h00A1, 16'h00A1, 2'd2));
    tbl.push_back(mk(1, 1, 0, 1, 16'h00E5, 0, 1, 16'h00B2, 16'h00B2, 2'd1));
    tbl.push_back(mk(1, 1, 0, 1, 16'h00E5, 0, 1, 16'h0000, 16'h00E5, 2'd1));
    tbl.push_back(mk(1, 0, 0, 0, 16'h00A1, 1, 1, 16'h0000, 16'h00E5, 2'd2));
`else
    // Streaming, no gaps.
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back(mk(1, 0, 0, 1, 16'(k), 1, 1, 16'(k), 16'(k), 2'd1));
    end
    // Backpressure: in_ready follows out_ready combinationally.
    tbl.push_back(mk(1, 0, 0, 0, 16'h0009, 0, 1, 16'h0008, 16'h0008, 2'd1));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0009, 1, 1, 16'h0009, 16'h0009, 2'd1));
    // Drain with nothing behind; outputs hold their last value.
    tbl.push_back(mk(0, 0, 0, 1, 16'h00AA, 1, 0, 16'h0009, 16'h0009, 2'd0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h00BB, 1, 0, 16'h0009, 16'h0009, 2'd0));
    // Bubble into empty stage, held when blocked, retried on out_ready.
    tbl.push_back(mk(1, 1, 0, 0, 16'h00F5, 0, 1, 16'h0000, 16'h00F5, 2'd1));
    tbl.push_back(mk(1, 1, 0, 0, 16'h1234, 0, 1, 16'h0000, 16'h00F5, 2'd1));
    tbl.push_back(mk(1, 1, 0, 1, 16'h12A5, 0, 1, 16'h1200, 16'h12A5, 2'd1));
    // Flush beats accept and bubble.
    tbl.push_back(mk(1, 0, 1, 0, 16'h0055, 0, 0, 16'h1200, 16'h12A5, 2'd0));
    tbl.push_back(mk(1, 1, 1, 1, 16'h0066, 0, 0, 16'h1200, 16'h12A5, 2'd0));
    // Fill, block, release.
    tbl.push_back(mk(1, 0, 0, 0, 16'h0077, 1, 1, 16'h0077, 16'h0077, 2'd1));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0088, 0, 1, 16'h0077, 16'h0077, 2'd1));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0088, 1, 1, 16'h0088, 16'h0088, 2'd1));
`endif

    foreach (tbl[i]) apply(tbl[i], i);

    reset_pulse("midrst");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
